pll_cfg_writer: RTL and testbench
=================================

PLL_CFG_WRITER -- requirements
Module: pll_cfg_writer

Interface
- REQ-001 SHALL have parameter LOCK_TIMEOUT, default 65535: max cycles to wait for lock after START is accepted.
- REQ-002 SHALL have parameter SETTLE, default 16: minimum cycles after START acceptance before lock is honoured.
- REQ-003 clk  in  1  single clock for all logic, shared with the PLL reconfig management port.
- REQ-004 rst  in  1  synchronous, active-high reset.
- REQ-005 cfg_req  in  1  one-cycle request to reconfigure; ignored while busy=1.
- REQ-006 cfg_m_hi, cfg_m_lo  in  8 each  M counter high/low counts.
- REQ-007 cfg_m_odd  in  1  M odd-division duty enable.
- REQ-008 cfg_k  in  32  M fractional (K) value.
- REQ-009 cfg_c_sel  in  5  C counter index (0..17).
- REQ-010 cfg_c_hi, cfg_c_lo  in  8 each  C counter high/low counts.
- REQ-011 cfg_c_odd  in  1  C odd-division duty enable.
- REQ-012 mgmt_address  out  6  word address to the PLL reconfig responder.
- REQ-013 mgmt_write  out  1  write strobe.
- REQ-014 mgmt_writedata  out  32  write data.
- REQ-015 mgmt_waitrequest  in  1  responder stall; a write completes on a cycle with mgmt_write=1 and mgmt_waitrequest=0.
- REQ-016 pll_locked  in  1  PLL locked, already synchronous to clk.
- REQ-017 busy  out  1  sequence in progress.
- REQ-018 done  out  1  one-cycle pulse on successful completion.
- REQ-019 err  out  1  sticky lock-timeout flag; cleared on next accepted cfg_req.

Function
- REQ-020 Accepted cfg_req (busy=0) SHALL latch all cfg_* inputs into internal registers; later input changes have no effect until the next accept.
- REQ-021 State sequence SHALL be IDLE -> MODE -> WR_M -> WR_K -> WR_C -> START -> WAIT_LOCK -> IDLE, one write per write state.
- REQ-022 Writes SHALL be: MODE addr 0x00 data 0; WR_M addr 0x04 data {14'b0, m_odd, 1'b0, m_hi, m_lo}; WR_K addr 0x07 data k; WR_C addr 0x05 data {9'b0, c_sel, c_odd, 1'b0, c_hi, c_lo}; START addr 0x02 data 1.
- REQ-023 In each write state, mgmt_write SHALL be 1, with address/data stable until mgmt_waitrequest=0; the state advances on the next edge.
- REQ-024 The first write (MODE) SHALL assert mgmt_write in the cycle after cfg_req is accepted; there are no idle cycles between consecutive writes.
- REQ-025 mgmt_write SHALL be 0 in IDLE and WAIT_LOCK; mgmt_address/mgmt_writedata are don't-care when mgmt_write=0.
- REQ-026 In WAIT_LOCK, a 17-bit counter SHALL start from 0 at START acceptance and increment each cycle.
- REQ-027 Exit to IDLE with done=1 (one cycle) SHALL occur when counter >= SETTLE and pll_locked=1.
- REQ-028 When counter == LOCK_TIMEOUT without lock, the block SHALL set err=1, return to IDLE, and assert no done.
- REQ-029 busy SHALL be 1 in every state except IDLE; busy falls in the same cycle that done pulses.
- REQ-030 cfg_req coincident with the done cycle SHALL be ignored; a request is accepted only when busy=0.
- REQ-031 A write stalled indefinitely by mgmt_waitrequest SHALL hold (no timeout on writes).

Reset
- REQ-032 rst=1 at a clock edge SHALL force IDLE and busy=0, done=0, err=0, mgmt_write=0, mgmt_address=0, mgmt_writedata=0, counter=0, and all latched cfg registers=0.
- REQ-033 rst asserted mid-write SHALL drop mgmt_write at the next edge without completing the sequence; no done is issued.

Verification
- REQ-034 Basic: waitrequest=0, locked rises 20 cycles after START, req with m_hi=9,m_lo=9,k=0,c_sel=0,c_hi=5,c_lo=5 -> writes 0x00:0, 0x04:0x0909, 0x07:0, 0x05:0x0505, 0x02:1 on 5 consecutive cycles; done pulse; busy=0.
- REQ-035 Stall: waitrequest=1 for 3 cycles on WR_C -> C write held 4 cycles with stable addr/data, then the sequence resumes; done still pulses.
- REQ-036 Odd/select: c_sel=1, c_hi=8, c_lo=7, c_odd=1 -> WR_C data 0x0006_0807.
- REQ-037 Timeout: LOCK_TIMEOUT=100, locked held 0 -> err=1 exactly 100 cycles after START acceptance, no done; the next req clears err.
- REQ-038 Early lock: locked=1 throughout -> done occurs at counter=SETTLE, not before.
- REQ-039 Busy/reset: req pulses while busy are ignored (exactly 5 writes occur); rst during WR_K -> all outputs zero at the next edge, and a new req then restarts at MODE.

Source files
------------

// File: rtl/pll_cfg_writer_if.sv
// PLL reconfiguration management port.
// Groups the write-only memory-mapped bus between the config writer and the reconfig responder.
//   address     : word address of the current write
//   write       : write strobe
//   writedata   : write data
//   waitrequest : responder stall; a write completes when write=1 and waitrequest=0
interface pll_cfg_writer_if;
  logic [5:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;

  modport master (
    output address,
    output write,
    output writedata,
    input  waitrequest
  );

  modport slave (
    input  address,
    input  write,
    input  writedata,
    output waitrequest
  );
endinterface

// File: rtl/pll_cfg_writer.sv
// PLL reconfiguration sequencer.
// On an accepted cfg_req, latches the M/K/C settings and issues five writes to the PLL reconfig
// responder (MODE, M, K, C, START), then waits for pll_locked after a minimum settle time.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   cfg_req      : one-cycle reconfigure request, ignored while busy or during the done cycle
//   cfg_m_*      : M counter high/low counts and odd-division enable
//   cfg_k        : M fractional value
//   cfg_c_*      : C counter select, high/low counts and odd-division enable
//   mgmt         : management bus master (address/write/writedata/waitrequest)
//   pll_locked   : PLL lock indication, synchronous to clk
//   busy         : sequence in progress
//   done         : one-cycle pulse on successful lock
//   err          : sticky lock-timeout flag, cleared by the next accepted request
module pll_cfg_writer #(
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned SETTLE       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_req,
  input  logic [7:0]         cfg_m_hi,
  input  logic [7:0]         cfg_m_lo,
  input  logic               cfg_m_odd,
  input  logic [31:0]        cfg_k,
  input  logic [4:0]         cfg_c_sel,
  input  logic [7:0]         cfg_c_hi,
  input  logic [7:0]         cfg_c_lo,
  input  logic               cfg_c_odd,
  pll_cfg_writer_if.master   mgmt,
  input  logic               pll_locked,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    StIdle,
    StMode,
    StWrM,
    StWrK,
    StWrC,
    StStart,
    StWaitLock
  } state_e;

  localparam logic [5:0] AddrMode  = 6'h00;
  localparam logic [5:0] AddrM     = 6'h04;
  localparam logic [5:0] AddrK     = 6'h07;
  localparam logic [5:0] AddrC     = 6'h05;
  localparam logic [5:0] AddrStart = 6'h02;

  state_e      state_q;
  logic [16:0] cnt_q;
  logic [7:0]  m_hi_q, m_lo_q, c_hi_q, c_lo_q;
  logic        m_odd_q, c_odd_q;
  logic [31:0] k_q;
  logic [4:0]  c_sel_q;

  // cnt_q is 0 in the first WAIT_LOCK cycle, so elapsed is the number of cycles since START
  // was accepted, counting the cycle being evaluated.
  logic [17:0] elapsed;
  assign elapsed = {1'b0, cnt_q} + 18'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      m_hi_q         <= '0;
      m_lo_q         <= '0;
      m_odd_q        <= 1'b0;
      k_q            <= '0;
      c_sel_q        <= '0;
      c_hi_q         <= '0;
      c_lo_q         <= '0;
      c_odd_q        <= 1'b0;
      mgmt.address   <= '0;
      mgmt.write     <= 1'b0;
      mgmt.writedata <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // done is still high in the cycle busy falls; a request then is dropped.
          if (cfg_req && !done) begin
            m_hi_q         <= cfg_m_hi;
            m_lo_q         <= cfg_m_lo;
            m_odd_q        <= cfg_m_odd;
            k_q            <= cfg_k;
            c_sel_q        <= cfg_c_sel;
            c_hi_q         <= cfg_c_hi;
            c_lo_q         <= cfg_c_lo;
            c_odd_q        <= cfg_c_odd;
            err            <= 1'b0;
            busy           <= 1'b1;
            mgmt.write     <= 1'b1;
            mgmt.address   <= AddrMode;
            mgmt.writedata <= 32'd0;
            state_q        <= StMode;
          end
        end
        StMode: begin
          if (!mgmt.waitrequest) begin
            mgmt.address   <= AddrM;
            mgmt.writedata <= {14'b0, m_odd_q, 1'b0, m_hi_q, m_lo_q};
            state_q        <= StWrM;
          end
        end
        StWrM: begin
          if (!mgmt.waitrequest) begin
            mgmt.address   <= AddrK;
            mgmt.writedata <= k_q;
            state_q        <= StWrK;
          end
        end
        StWrK: begin
          if (!mgmt.waitrequest) begin
            mgmt.address   <= AddrC;
            mgmt.writedata <= {9'b0, c_sel_q, c_odd_q, 1'b0, c_hi_q, c_lo_q};
            state_q        <= StWrC;
          end
        end
        StWrC: begin
          if (!mgmt.waitrequest) begin
            mgmt.address   <= AddrStart;
            mgmt.writedata <= 32'd1;
            state_q        <= StStart;
          end
        end
        StStart: begin
          if (!mgmt.waitrequest) begin
            mgmt.write <= 1'b0;
            cnt_q      <= '0;
            state_q    <= StWaitLock;
          end
        end
        StWaitLock: begin
          if (elapsed >= 18'(SETTLE) && pll_locked) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else if (elapsed >= 18'(LOCK_TIMEOUT)) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 17'd1;
          end
        end
        default: begin
          mgmt.write <= 1'b0;
          busy       <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_cfg_writer.sv
// Self-checking bench for pll_cfg_writer: scoreboarded management writes, lock/timeout timing,
// stall handling, request filtering and reset behaviour.
module tb_pll_cfg_writer;
  localparam int LockTimeout = 100;
  localparam int Settle      = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_req;
  logic [7:0]  cfg_m_hi, cfg_m_lo, cfg_c_hi, cfg_c_lo;
  logic        cfg_m_odd, cfg_c_odd;
  logic [31:0] cfg_k;
  logic [4:0]  cfg_c_sel;
  logic        pll_locked;
  logic        busy, done, err;

  pll_cfg_writer_if mgmt ();

  pll_cfg_writer #(
    .LOCK_TIMEOUT (LockTimeout),
    .SETTLE       (Settle)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_req    (cfg_req),
    .cfg_m_hi   (cfg_m_hi),
    .cfg_m_lo   (cfg_m_lo),
    .cfg_m_odd  (cfg_m_odd),
    .cfg_k      (cfg_k),
    .cfg_c_sel  (cfg_c_sel),
    .cfg_c_hi   (cfg_c_hi),
    .cfg_c_lo   (cfg_c_lo),
    .cfg_c_odd  (cfg_c_odd),
    .mgmt       (mgmt),
    .pll_locked (pll_locked),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    int          gap;
  } wr_t;
  wr_t exp_q[$];

  // Responder model: stall the C write for stall_req cycles.
  int stall_req = 0;
  int stall_cnt = 0;
  assign mgmt.waitrequest = mgmt.write && (mgmt.address == 6'h05) && (stall_cnt < stall_req);

  int cyc = 0;
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    stall_cnt <= (mgmt.write && mgmt.address == 6'h05) ? stall_cnt + 1 : 0;
  end

  // Monitor, sampled on the falling edge. Edge numbers refer to the upcoming rising edge (cyc+1)
  // for handshakes, or the edge that produced the sampled value (cyc) for registered flags.
  int          last_evt = 0;
  int          n_writes = 0;
  int          n_extra  = 0;
  int          n_start  = 0;
  int          n_done   = 0;
  int          n_err    = 0;
  int          start_edge = 0;
  int          done_edge  = 0;
  int          err_edge   = 0;
  logic        err_prev   = 1'b0;
  logic        prev_stall = 1'b0;
  logic [5:0]  prev_addr;
  logic [31:0] prev_data;

  always @(negedge clk) begin
    if (!rst) begin
      if (cfg_req && !busy && !done) last_evt = cyc + 1;
      if (prev_stall) begin
        check_val("stall_addr_stable", 32'(mgmt.address), 32'(prev_addr));
        check_val("stall_data_stable", mgmt.writedata, prev_data);
      end
      if (mgmt.write && !mgmt.waitrequest) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          n_extra++;
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          check_val("wr_addr", 32'(mgmt.address), 32'(w.addr));
          check_val("wr_data", mgmt.writedata, w.data);
          check_val("wr_gap", 32'(cyc + 1 - last_evt), 32'(w.gap));
        end
        last_evt = cyc + 1;
        if (mgmt.address == 6'h02) begin
          start_edge = cyc + 1;
          n_start++;
        end
      end
      if (done) begin
        done_edge = cyc;
        n_done++;
        check_val("busy_low_at_done", 32'(busy), 32'd0);
      end
      if (err && !err_prev) begin
        err_edge = cyc;
        n_err++;
      end
    end
    err_prev   = err;
    prev_stall = mgmt.write && mgmt.waitrequest;
    prev_addr  = mgmt.address;
    prev_data  = mgmt.writedata;
  end

  task automatic push_writes(input logic [7:0] mh, input logic [7:0] ml, input logic mo,
                             input logic [31:0] k, input logic [4:0] cs, input logic [7:0] ch,
                             input logic [7:0] cl, input logic co, input int stall);
    wr_t w;
    w.addr = 6'h00; w.data = 32'd0; w.gap = 1; exp_q.push_back(w);
    w.addr = 6'h04; w.data = (32'(mo) << 17) | (32'(mh) << 8) | 32'(ml); exp_q.push_back(w);
    w.addr = 6'h07; w.data = k; exp_q.push_back(w);
    w.addr = 6'h05; w.gap = 1 + stall;
    w.data = (32'(cs) << 18) | (32'(co) << 17) | (32'(ch) << 8) | 32'(cl);
    exp_q.push_back(w);
    w.addr = 6'h02; w.data = 32'd1; w.gap = 1; exp_q.push_back(w);
  endtask

  task automatic issue_req(input logic [7:0] mh, input logic [7:0] ml, input logic mo,
                           input logic [31:0] k, input logic [4:0] cs, input logic [7:0] ch,
                           input logic [7:0] cl, input logic co);
    cfg_m_hi = mh; cfg_m_lo = ml; cfg_m_odd = mo; cfg_k = k;
    cfg_c_sel = cs; cfg_c_hi = ch; cfg_c_lo = cl; cfg_c_odd = co;
    cfg_req = 1'b1;
    @(posedge clk);
    #1;
    cfg_req = 1'b0;
    // Later input changes must not reach the writes.
    cfg_m_hi = 8'($urandom); cfg_m_lo = 8'($urandom); cfg_m_odd = 1'($urandom);
    cfg_k = $urandom; cfg_c_sel = 5'($urandom); cfg_c_hi = 8'($urandom);
    cfg_c_lo = 8'($urandom); cfg_c_odd = 1'($urandom);
  endtask

  // lock_delay: -1 never locks, 0 locked throughout, N>0 locked set N cycles after START.
  task automatic run_cfg(input logic [7:0] mh, input logic [7:0] ml, input logic mo,
                         input logic [31:0] k, input logic [4:0] cs, input logic [7:0] ch,
                         input logic [7:0] cl, input logic co, input int stall,
                         input int lock_delay, input int extra_reqs, input bit coin_req);
    int s0, d0, e0, w0, x0, t, exp_done;
    stall_req  = stall;
    pll_locked = (lock_delay == 0);
    push_writes(mh, ml, mo, k, cs, ch, cl, co, stall);
    s0 = n_start; d0 = n_done; e0 = n_err; w0 = n_writes; x0 = n_extra;
    issue_req(mh, ml, mo, k, cs, ch, cl, co);
    check_val("busy_after_accept", 32'(busy), 32'd1);
    check_val("err_cleared_on_accept", 32'(err), 32'd0);
    for (int i = 0; i < extra_reqs; i++) begin
      cfg_req = 1'b1;
      @(posedge clk);
      #1;
      cfg_req = 1'b0;
    end
    t = 0;
    while (n_start == s0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check_val("start_write_seen", 32'(n_start - s0), 32'd1);
    if (lock_delay > 0) begin
      repeat (lock_delay) @(posedge clk);
      #1;
      pll_locked = 1'b1;
    end
    if (coin_req) begin
      repeat (Settle) @(posedge clk);
      #1;
      cfg_req = 1'b1;
      @(posedge clk);
      #1;
      cfg_req = 1'b0;
    end
    t = 0;
    while (n_done == d0 && n_err == e0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    if (lock_delay >= 0) begin
      exp_done = (lock_delay + 1 > Settle) ? lock_delay + 1 : Settle;
      check_val("done_pulses", 32'(n_done - d0), 32'd1);
      check_val("done_latency", 32'(done_edge - start_edge), 32'(exp_done));
      check_val("err_low_after_done", 32'(err), 32'd0);
    end else begin
      check_val("err_set", 32'(err), 32'd1);
      check_val("err_latency", 32'(err_edge - start_edge), 32'(LockTimeout));
      check_val("no_done_on_timeout", 32'(n_done - d0), 32'd0);
    end
    check_val("idle_busy", 32'(busy), 32'd0);
    check_val("idle_write", 32'(mgmt.write), 32'd0);
    check_val("write_count", 32'(n_writes - w0), 32'd5);
    check_val("unexpected_writes", 32'(n_extra - x0), 32'd0);
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    pll_locked = 1'b0;
    stall_req  = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_write"}, 32'(mgmt.write), 32'd0);
    check_val({tag, "_addr"}, 32'(mgmt.address), 32'd0);
    check_val({tag, "_data"}, mgmt.writedata, 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int t, d0;
    rst = 1'b1; cfg_req = 1'b0; pll_locked = 1'b0;
    cfg_m_hi = '0; cfg_m_lo = '0; cfg_m_odd = 1'b0; cfg_k = '0;
    cfg_c_sel = '0; cfg_c_hi = '0; cfg_c_lo = '0; cfg_c_odd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic, lock 20 cycles after START.
    run_cfg(8'd9, 8'd9, 1'b0, 32'd0, 5'd0, 8'd5, 8'd5, 1'b0, 0, 20, 0, 1'b0);
    // C write stalled 3 cycles, with requests pulsed while busy.
    run_cfg(8'd3, 8'd2, 1'b1, 32'h1234_5678, 5'd4, 8'd1, 8'd2, 1'b0, 3, 20, 2, 1'b0);
    // Odd/select encoding.
    run_cfg(8'd10, 8'd11, 1'b0, 32'hdead_beef, 5'd1, 8'd8, 8'd7, 1'b1, 0, 5, 0, 1'b0);
    // Lock timeout.
    run_cfg(8'd1, 8'd1, 1'b0, 32'd7, 5'd17, 8'd1, 8'd1, 1'b0, 0, -1, 0, 1'b0);
    // Early lock clears err; a request coincident with done is dropped.
    run_cfg(8'd4, 8'd4, 1'b1, 32'h0000_ffff, 5'd2, 8'd6, 8'd6, 1'b1, 0, 0, 0, 1'b1);
    // Timeout again, then reset clears the sticky err.
    run_cfg(8'd2, 8'd2, 1'b0, 32'd1, 5'd3, 8'd2, 8'd2, 1'b0, 0, -1, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero_outputs("rst_clears_err");

    // Reset during WR_K.
    d0 = n_done;
    push_writes(8'd5, 8'd6, 1'b0, 32'h55aa_55aa, 5'd0, 8'd3, 8'd3, 1'b0, 0);
    issue_req(8'd5, 8'd6, 1'b0, 32'h55aa_55aa, 5'd0, 8'd3, 8'd3, 1'b0);
    t = 0;
    while (!(mgmt.write && mgmt.address == 6'h07) && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_val("reached_wr_k", 32'(mgmt.address), 32'h07);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero_outputs("rst_mid_write");
    rst = 1'b0;
    exp_q.delete();
    pll_locked = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check_val("no_done_after_reset", 32'(n_done - d0), 32'd0);
    check_val("idle_after_reset", 32'(busy), 32'd0);
    // Fresh request restarts at MODE.
    run_cfg(8'd7, 8'd8, 1'b1, 32'h0bad_cafe, 5'd9, 8'd4, 8'd3, 1'b1, 0, 20, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
